seven_seg_scan_ctrl: RTL
========================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-division scan controller for a 4-digit common-anode 7-segment display (Basys3 style).
//  Takes a 16-bit hex value and drives active-low an[3:0] and cathode[6:0], one digit per slot.
//  Inserts a blanking gap before each digit to prevent ghosting.
//  Accepts new values by valid/ready and applies them only at frame boundaries (tear-free).
//  Output feeds the DE10-Lite display latch adapter, or Basys3 pins directly.
// PARAMETERS
//  DIGIT_TICKS  50000  clock cycles a digit is driven (1 ms @ 50 MHz); must be >= 1
//  BLANK_TICKS  500    clock cycles all anodes are off before each digit; must be >= 1
// PORTS
//  max10_clk1_50  in   1   system clock, 50 MHz
//  reset_n        in   1   synchronous, active-low reset
//  value          in   16  digit3=value[15:12] ... digit0=value[3:0]
//  value_valid    in   1   value offered
//  value_ready    out  1   pending buffer empty; handshake = value_valid & value_ready
//  digit_en       in   4   per-digit enable; a disabled digit keeps its slot but its anode stays high
//  lz_suppress    in   1   blank leading zero digits 3..1 (digit0 is never suppressed)
//  an             out  4   anodes, active low, registered
//  cathode        out  7   segments, active low, cathode[0]=a ... cathode[6]=g, registered
//  frame_start    out  1   one-cycle pulse on first BLANK cycle of digit0
// BEHAVIOUR
//  Reset (reset_n=0 at clock edge): an=4'hF, cathode=7'h7F, value_ready=1, frame_start=0,
//    shadow=0, pending empty, idx=0, state=BLANK, tick counter=0.
//  FSM:
//    BLANK: lasts BLANK_TICKS cycles; an=4'hF, cathode=7'h7F; then -> SHOW.
//    SHOW: lasts DIGIT_TICKS cycles, then -> BLANK with idx=idx+1 mod 4 (3 wraps to 0).
//  Frame: 4*(BLANK_TICKS+DIGIT_TICKS) cycles.
//  Frame boundary: first cycle of BLANK with idx=0, including the first cycle after reset release.
//    frame_start=1 for exactly that cycle.
//  SHOW outputs:
//    an: bit idx = 0 if digit_en[idx] is 1 and the digit is not suppressed; otherwise all 1.
//    cathode = decode(shadow nibble idx) when lit; 7'h7F when not lit.
//  Leading-zero suppression: digit i (i=1..3) is suppressed when lz_suppress=1 and
//    shadow nibbles i..3 are all 0.
//  Decode table (active low): 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12 6=7'h02 7=7'h78
//    8=7'h00 9=7'h10 A=7'h08 b=7'h03 C=7'h46 d=7'h21 E=7'h06 F=7'h0E.
//  Timing: outputs are registered and take effect on the cycle the state/idx changes.
//    No combinational path from inputs to outputs.
//  Handshake:
//    On a cycle with valid&ready, value is captured into the pending buffer and value_ready=0
//      from the next cycle.
//    At the next frame boundary, pending->shadow and value_ready=1 on the following cycle.
//    The new shadow is used from the digit0 SHOW of that frame.
//  Simultaneous events: a capture on the boundary cycle itself is not applied in that cycle;
//    it waits for the next boundary. A value is never lost or duplicated.
//  value_valid with value_ready=0: ignored; the source must hold it.
//  digit_en and lz_suppress are sampled live every SHOW cycle; they are not frame-synchronised.
//  Reset mid-frame: abandons the slot, discards pending, blanks outputs on the next edge.
//  Counter width: $clog2(max(DIGIT_TICKS,BLANK_TICKS)+1); no overflow at max count.
// STRUCTURE
//  Package seven_seg_pkg:
//    NUM_DIGITS=4
//    typedef enum logic {SCAN_BLANK, SCAN_SHOW} scan_state_t
//    SEG_OFF=7'h7F, AN_OFF=4'hF
//    function hex_to_seg(logic [3:0]) returning the decode table
//  Sub-module seven_seg_decode: combinational nibble -> cathode, wraps hex_to_seg.
//  Top holds the FSM, tick counter, idx, shadow/pending registers and output registers.
// TESTING  (sim with DIGIT_TICKS=4, BLANK_TICKS=2; frame = 24 cycles)
//  1. Reset, then release. Required: an=F, cathode=7F, value_ready=1.
//     frame_start pulses in the first cycle after release.
//     an=4'b1110 with cathode=7'h40 from cycle 2 to cycle 5.
//  2. Push value=16'h1A3F mid-frame. Required: value_ready low until the next boundary.
//     The following frame shows digit0=7'h0E, digit1=7'h30, digit2=7'h08, digit3=7'h79.
//     Each digit lasts 4 cycles, separated by 2 all-off cycles.
//  3. value=16'h0007 with lz_suppress=1. Required: only an[0] ever goes low (cathode 7'h78).
//     With lz_suppress=0, digits 3..1 show 7'h40.
//  4. digit_en=4'b0101. Required: an[1] and an[3] are never low.
//     Slot timing is unchanged (frame_start period stays 24 cycles).
//  5. Hold value_valid high across a boundary with two different values.
//     Required: exactly one capture per frame; values are applied in order; none lost.
//  6. Assert reset_n=0 for 1 cycle during digit2 SHOW with a value pending.
//     Required: outputs blank next edge, the pending value is discarded, shadow=0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the 4-digit 7-segment scan controller: digit count,
// scan FSM state type, active-low "all off" patterns and the hex decode table.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {SCAN_BLANK, SCAN_SHOW} scan_state_t;

    // Active-low patterns that leave every segment / every anode dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Hex nibble to active-low segments, cathode[0]=a ... cathode[6]=g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// -----------------------------------------------------------------------------
// seven_seg_decode
// Combinational hex nibble to active-low 7-segment pattern.
// Ports:
//   nibble  in  4  hex digit to display
//   seg     out 7  active-low segments, seg[0]=a ... seg[6]=g
// -----------------------------------------------------------------------------
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_ctrl
// Time-division scan controller for a 4-digit common-anode 7-segment display.
// Each digit slot is BLANK_TICKS cycles with every anode off (anti-ghosting)
// followed by DIGIT_TICKS cycles driving that digit. New values arrive over a
// valid/ready handshake into a one-entry pending buffer and are copied into the
// displayed (shadow) value only at a frame boundary, so a frame never tears.
// Ports:
//   max10_clk1_50  in   1   system clock
//   reset_n        in   1   synchronous active-low reset
//   value          in   16  digit3=value[15:12] ... digit0=value[3:0]
//   value_valid    in   1   value offered
//   value_ready    out  1   pending buffer empty
//   digit_en       in   4   per-digit enable (disabled digit keeps its slot, stays dark)
//   lz_suppress    in   1   blank leading zero digits 3..1
//   an             out  4   anodes, active low, registered
//   cathode        out  7   segments, active low, registered
//   frame_start    out  1   one-cycle pulse on the first BLANK cycle of digit0
// -----------------------------------------------------------------------------
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_TICKS = 50000,
    parameter int BLANK_TICKS = 500
) (
    input  logic        max10_clk1_50,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic [3:0]  digit_en,
    input  logic        lz_suppress,
    output logic [3:0]  an,
    output logic [6:0]  cathode,
    output logic        frame_start
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS);
    localparam logic [CNT_W-1:0] CNT_FIRST  = CNT_W'(1);

    scan_state_t      state;
    logic [1:0]       idx;
    // Counts 1..N inside a slot; 0 only in the reset state, which marks the
    // cycle before the first frame boundary.
    logic [CNT_W-1:0] tick_cnt;
    logic [15:0]      shadow;
    logic [15:0]      pending;

    logic             slot_done;
    logic             show_next;
    logic [3:0]       suppress;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg;
    logic             digit_lit;

    // Outputs are registered from what the FSM will be doing in the next
    // cycle, so an/cathode change on the same edge as state/idx.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        slot_done  = 1'b0;
        show_next  = 1'b0;
        suppress   = 4'b0000;
        cur_nibble = shadow[{idx, 2'b00} +: 4];

        if (state == SCAN_BLANK) begin
            slot_done = (tick_cnt == BLANK_LAST);
            show_next = slot_done;
        end else begin
            slot_done = (tick_cnt == DIGIT_LAST);
            show_next = !slot_done;
        end

        // Digit i is a leading zero when it and every digit above it are zero.
        suppress[1] = lz_suppress && (shadow[15:4]  == 12'h000);
        suppress[2] = lz_suppress && (shadow[15:8]  == 8'h00);
        suppress[3] = lz_suppress && (shadow[15:12] == 4'h0);

        digit_lit = show_next && digit_en[idx] && !suppress[idx];
    end

    seven_seg_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge max10_clk1_50) begin
        if (!reset_n) begin
            state       <= SCAN_BLANK;
            idx         <= 2'd0;
            tick_cnt    <= '0;
            shadow      <= 16'h0000;
            value_ready <= 1'b1;
            an          <= AN_OFF;
            cathode     <= SEG_OFF;
            frame_start <= 1'b0;
            // NOTE: pending data is not reset; value_ready=1 already marks it
            // empty, so its contents are never looked at until rewritten.
        end else begin
            case (state)
                SCAN_BLANK: begin
                    if (slot_done) begin
                        state    <= SCAN_SHOW;
                        tick_cnt <= CNT_FIRST;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                SCAN_SHOW: begin
                    if (slot_done) begin
                        state    <= SCAN_BLANK;
                        idx      <= idx + 2'd1;
                        tick_cnt <= CNT_FIRST;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
            endcase

            // Next cycle is a frame boundary: leaving reset, or digit3 ending.
            frame_start <= ((state == SCAN_BLANK) && (tick_cnt == '0)) ||
                           ((state == SCAN_SHOW) && slot_done && (idx == 2'd3));

            an      <= digit_lit ? ~(4'b0001 << idx) : AN_OFF;
            cathode <= digit_lit ? cur_seg : SEG_OFF;

            // A capture needs an empty buffer and a transfer needs a full one,
            // so the two branches can never both apply. Transfer happens at the
            // end of the boundary cycle, so a value captured during that cycle
            // waits for the next frame.
            if (value_valid && value_ready) begin
                pending     <= value;
                value_ready <= 1'b0;
            end else if (frame_start && !value_ready) begin
                shadow      <= pending;
                value_ready <= 1'b1;
            end
        end
    end

endmodule
